// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: self-timed column scanner with double-buffered frame and per-column blanking.
// Optional MATRIX_MIRROR_EN: columns c >= COLS/2 show column COLS-1-c.
module led_matrix_scanner #(
  parameter int ROWS  = 7,
  parameter int COLS  = 5,
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 load,
  output logic                 pending,
  output logic [COLS-1:0]      col_sel,
  output logic [ROWS-1:0]      rows,
  output logic                 frame_done
);
  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2((DWELL > BLANK ? DWELL : BLANK) + 1);
  localparam int IW = $clog2(COLS);
  localparam logic [CW-1:0] BL_END = CW'(BLANK - 1);
  localparam logic [CW-1:0] DW_END = CW'(DWELL - 1);
  localparam logic [IW-1:0] LAST   = IW'(COLS - 1);
  typedef enum logic {S_BLANK, S_DRIVE} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   src;
  logic [N-1:0]    active;
  logic [N-1:0]    shadow;
`ifdef MATRIX_MIRROR_EN
  assign src = (int'(idx) >= COLS / 2) ? IW'(COLS - 1 - int'(idx)) : idx;
`else
  assign src = idx;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_BLANK;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      col_sel    <= '0;
      rows       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        shadow  <= frame_in;
        pending <= 1'b1;
      end
      if (!enable) begin
        state   <= S_BLANK;
        cnt     <= '0;
        idx     <= '0;
        col_sel <= '0;
        rows    <= '0;
      end else if (state == S_BLANK) begin
        if (cnt == BL_END) begin
          state   <= S_DRIVE;
          cnt     <= '0;
          col_sel <= COLS'(1) << idx;
          rows    <= active[src*ROWS +: ROWS];
        end else cnt <= cnt + 1'b1;
      end else if (cnt == DW_END) begin
        state   <= S_BLANK;
        cnt     <= '0;
        col_sel <= '0;
        rows    <= '0;
        idx     <= (idx == LAST) ? '0 : idx + 1'b1;
        // Frame boundary: swap in the shadow; a same-cycle load keeps pending set.
        if (idx == LAST) begin
          frame_done <= 1'b1;
          if (pending) begin
            active <= shadow;
            if (!load) pending <= 1'b0;
          end
        end
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: directed table plus multi-cycle sequences for led_matrix_scanner.
module tb_led_matrix_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        load = 1'b0;
  logic [34:0] frame_in = '0;
  logic        pending;
  logic        frame_done;
  logic [4:0]  col_sel;
  logic [6:0]  rows;
  int t = 0;
  int checks = 0;
  int failures = 0;

  led_matrix_scanner #(.ROWS(7), .COLS(5), .DWELL(4), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_in(frame_in), .load(load),
    .pending(pending), .col_sel(col_sel), .rows(rows), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [4:0] col;
    logic [6:0] rows;
    logic       fd;
    logic       pend;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_to(input int n);
    while (t < n) step();
  endtask

  task automatic ld(input logic [34:0] f);
    frame_in = f;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  function automatic logic [34:0] mk(input logic [6:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  function automatic logic [6:0] erows(input logic [34:0] f, input int c);
    int s;
    logic [34:0] v;
    s = c;
`ifdef MATRIX_MIRROR_EN
    if (c >= 2) s = 4 - c;
`endif
    v = f >> (s * 7);
    return v[6:0];
  endfunction

  task automatic chk_col(input string nm, input int c, input logic [6:0] r);
    chk({nm, "_col"}, 32'(col_sel), 32'(5'd1 << c));
    chk({nm, "_rows"}, 32'(rows), 32'(r));
  endtask

  logic [34:0] fa, fb1, fb2, fc, fd, fm;

  initial begin
    tbl[0]  = '{0,  5'b00000, 7'h00, 1'b0, 1'b0};
    tbl[1]  = '{1,  5'b00000, 7'h00, 1'b0, 1'b0};
    tbl[2]  = '{2,  5'b00001, 7'h00, 1'b0, 1'b0};
    tbl[3]  = '{5,  5'b00001, 7'h00, 1'b0, 1'b0};
    tbl[4]  = '{6,  5'b00000, 7'h00, 1'b0, 1'b0};
    tbl[5]  = '{7,  5'b00000, 7'h00, 1'b0, 1'b0};
    tbl[6]  = '{8,  5'b00010, 7'h00, 1'b0, 1'b0};
    tbl[7]  = '{26, 5'b10000, 7'h00, 1'b0, 1'b0};
    tbl[8]  = '{29, 5'b10000, 7'h00, 1'b0, 1'b0};
    tbl[9]  = '{30, 5'b00000, 7'h00, 1'b1, 1'b0};
    tbl[10] = '{31, 5'b00000, 7'h00, 1'b0, 1'b0};
    tbl[11] = '{32, 5'b00001, 7'h00, 1'b0, 1'b0};
    fa  = mk(7'h01, 7'h02, 7'h04, 7'h08, 7'h10);
    fb1 = mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    fb2 = mk(7'h40, 7'h20, 7'h10, 7'h08, 7'h04);
    fc  = mk(7'h11, 7'h11, 7'h11, 7'h11, 7'h11);
    fd  = mk(7'h22, 7'h22, 7'h22, 7'h22, 7'h22);
    fm  = mk(7'h7F, 7'h2A, 7'h55, 7'h00, 7'h00);
    step();
    step();
    t = 0;
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      run_to(tbl[i].t);
      chk("tbl_col", 32'(col_sel), 32'(tbl[i].col));
      chk("tbl_rows", 32'(rows), 32'(tbl[i].rows));
      chk("tbl_fd", 32'(frame_done), 32'(tbl[i].fd));
      chk("tbl_pend", 32'(pending), 32'(tbl[i].pend));
    end
    run_to(35);
    ld(fa);
    chk("load_pend", 32'(pending), 32'd1);
    run_to(38);
    chk_col("old_data", 1, 7'h00);
    run_to(59);
    chk("pend_hold", 32'(pending), 32'd1);
    run_to(60);
    chk("swap_fd", 32'(frame_done), 32'd1);
    chk("swap_pend", 32'(pending), 32'd0);
    for (int c = 0; c < 5; c++) begin
      run_to(62 + 6 * c);
      chk_col("frame_a", c, erows(fa, c));
    end
    run_to(65);
    ld(fb1);
    chk("two_pend1", 32'(pending), 32'd1);
    run_to(70);
    ld(fb2);
    run_to(89);
    chk("two_pend2", 32'(pending), 32'd1);
    run_to(90);
    chk("two_pend0", 32'(pending), 32'd0);
    for (int c = 0; c < 5; c++) begin
      run_to(92 + 6 * c);
      chk_col("latest", c, erows(fb2, c));
    end
    run_to(100);
    ld(fc);
    run_to(119);
    ld(fd);
    chk("coin_pend", 32'(pending), 32'd1);
    chk("coin_fd", 32'(frame_done), 32'd1);
    run_to(122);
    chk_col("coin_c0", 0, erows(fc, 0));
    run_to(140);
    chk_col("coin_c3", 3, erows(fc, 3));
    run_to(149);
    chk("coin_pend_hold", 32'(pending), 32'd1);
    run_to(150);
    chk("coin_pend_clr", 32'(pending), 32'd0);
    run_to(152);
    chk_col("coin_next", 0, erows(fd, 0));
    run_to(165);
    chk_col("pre_dis", 2, erows(fd, 2));
    enable = 1'b0;
    step();
    chk("dis_col", 32'(col_sel), 32'd0);
    chk("dis_rows", 32'(rows), 32'd0);
    run_to(168);
    enable = 1'b1;
    step();
    chk("reen_dark", 32'(col_sel), 32'd0);
    step();
    chk_col("reen_c0", 0, erows(fd, 0));
    ld(fa);
    chk("pre_rst_pend", 32'(pending), 32'd1);
    rst_n = 1'b0;
    frame_in = fb1;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("rst_col", 32'(col_sel), 32'd0);
    chk("rst_rows", 32'(rows), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    t = 0;
    rst_n = 1'b1;
    run_to(2);
    chk_col("rst_active", 0, 7'h00);
    run_to(3);
    ld(fm);
    for (int c = 0; c < 5; c++) begin
      run_to(32 + 6 * c);
      chk_col("mirror", c, erows(fm, c));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
